frame_assembler: RTL and testbench
==================================

FRAME_ASSEMBLER -- requirements
Module: frame_assembler

Interface
REQ-001 The block SHALL take parameter BPS, default 16, meaning bits per audio sample.
REQ-002 The block SHALL take parameter FRAME_SIZE, default 8, meaning samples per frame.
REQ-003 Port in_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port in_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port in_sample, input, BPS bits: incoming audio sample.
REQ-006 Port in_sample_valid, input, 1 bit: in_sample is valid.
REQ-007 Port out_sample_ready, output, 1 bit: block accepts a sample this cycle.
REQ-008 Port in_msg_byte, input, 8 bits: next message byte.
REQ-009 Port in_msg_valid, input, 1 bit: in_msg_byte is valid.
REQ-010 Port in_msg_last, input, 1 bit: qualifies in_msg_byte as the final message byte.
REQ-011 Port out_msg_ready, output, 1 bit: block accepts a message byte this cycle.
REQ-012 Port out_frame, output, FRAME_SIZE*BPS bits: assembled frame; sample k occupies bits [k*BPS+BPS-1 : k*BPS].
REQ-013 Port out_message, output, FRAME_SIZE bits: bit k is the LSB value to embed in sample k.
REQ-014 Port out_enable, output, 1 bit: frame carries at least one message bit.
REQ-015 Port out_valid, output, 1 bit: out_frame, out_message and out_enable are valid.
REQ-016 Port in_ready, input, 1 bit: downstream embedding stage accepts the frame.

Function
REQ-017 Sample transfer SHALL occur when in_sample_valid and out_sample_ready are both high; byte transfer when in_msg_valid and out_msg_ready are both high; frame transfer when out_valid and in_ready are both high.
REQ-018 The FSM SHALL have two states: FILL (collecting samples) and HOLD (frame presented).
REQ-019 In FILL the block SHALL hold a sample counter 0..FRAME_SIZE-1; the n-th accepted sample of a frame SHALL be written to slot n.
REQ-020 On the sample transfer into slot FRAME_SIZE-1 the FSM SHALL go to HOLD and out_valid SHALL be high from the following cycle (latency 1 cycle).
REQ-021 In HOLD, out_frame, out_message and out_enable SHALL remain stable and out_sample_ready SHALL be low.
REQ-022 On frame transfer the FSM SHALL return to FILL with counter 0, out_valid low next cycle, and out_enable cleared for the new frame.
REQ-023 The block SHALL hold an 8-bit message buffer, a remaining-bit count 0..8, a last flag and a done flag.
REQ-024 out_msg_ready SHALL be high exactly when the remaining-bit count is 0 and done is low.
REQ-025 On byte transfer the buffer SHALL load in_msg_byte, the count SHALL become 8 and the last flag SHALL take in_msg_last.
REQ-026 out_sample_ready SHALL be high exactly when in FILL and (count nonzero or done high).
REQ-027 On sample transfer with count nonzero, out_message[slot] SHALL take buffer bit [count-1] (MSB first), count SHALL decrement and out_enable SHALL set.
REQ-028 If that decrement reaches 0 with the last flag set, done SHALL set and the last flag SHALL clear.
REQ-029 On sample transfer with done high, out_message[slot] SHALL take in_sample[0], so the embedding stage leaves that sample unchanged.
REQ-030 Byte load and bit consumption SHALL be mutually exclusive in a cycle; no byte loss or bit duplication.
REQ-031 A message ending mid-frame SHALL yield a frame with mixed message and pass-through bits and out_enable high.
REQ-032 Once done is set, all later frames SHALL have out_enable low; done clears only on reset.

Reset
REQ-033 While in_rst is high: FSM in FILL, counters 0, buffer 0, last and done 0, out_frame 0, out_message 0, out_enable 0, out_valid 0, out_msg_ready 1, out_sample_ready 0.
REQ-034 Reset asserted mid-frame or in HOLD SHALL discard partial frame and buffered bits immediately and asynchronously.

Verification
REQ-035 Byte 0xA5 (last=0) then 8 samples 0x1000..0x1007, in_ready=1 -> one frame, out_message=0xA5 (slot 0 = bit 7, so bit k = byte bit 7-k; value 0xA5), out_enable=1, out_valid 1 cycle after 8th sample.
REQ-036 Hold in_ready=0 for 5 cycles in HOLD -> outputs stable, out_sample_ready=0, no sample accepted; frame transferred on in_ready=1.
REQ-037 Byte 0xF0 with last=1, then 16 samples all 0x0001 -> frame 1 out_message=0x0F, out_enable=1; frame 2 out_message=0xFF (LSBs), out_enable=0; out_msg_ready stays 0.
REQ-038 No message byte offered, samples valid -> out_sample_ready=0, no sample accepted until a byte transfers.
REQ-039 Assert in_rst after 3 samples -> all outputs at reset values; next 8 samples form a clean frame with slot 0 = first post-reset sample.

Source files
------------

// File: rtl/frame_assembler.sv
// Collects audio samples into a frame and pairs each sample with the message
// bit to embed in its LSB, or its own LSB once the message has run out.
module frame_assembler #(
    parameter int BPS        = 16,
    parameter int FRAME_SIZE = 8
) (
    input  logic                      in_clk,
    input  logic                      in_rst,
    input  logic [BPS-1:0]            in_sample,
    input  logic                      in_sample_valid,
    output logic                      out_sample_ready,
    input  logic [7:0]                in_msg_byte,
    input  logic                      in_msg_valid,
    input  logic                      in_msg_last,
    output logic                      out_msg_ready,
    output logic [FRAME_SIZE*BPS-1:0] out_frame,
    output logic [FRAME_SIZE-1:0]     out_message,
    output logic                      out_enable,
    output logic                      out_valid,
    input  logic                      in_ready
);

    localparam int SLOT_W = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [SLOT_W-1:0] slot;
    logic [7:0]        msg_buf;
    logic [3:0]        bit_cnt;
    logic              last_flag;
    logic              done;
    logic              sample_fire;
    logic              byte_fire;
    logic              frame_fire;
    logic              last_slot;
    logic [2:0]        bit_idx;
    logic              embed_bit;

    // A byte can only load once every buffered bit is consumed, so loading
    // and consuming never collide in the same cycle.
    assign out_msg_ready    = (bit_cnt == 4'd0) && !done;
    assign out_sample_ready = (state == FILL) && ((bit_cnt != 4'd0) || done);
    assign out_valid        = (state == HOLD);

    assign sample_fire = in_sample_valid && out_sample_ready;
    assign byte_fire   = in_msg_valid && out_msg_ready;
    assign frame_fire  = out_valid && in_ready;
    assign last_slot   = (slot == SLOT_W'(FRAME_SIZE - 1));

    assign bit_idx   = 3'(bit_cnt - 4'd1);
    assign embed_bit = (bit_cnt != 4'd0) ? msg_buf[bit_idx] : in_sample[0];

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (sample_fire && last_slot) state_next = HOLD;
            HOLD:    if (frame_fire) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            slot        <= '0;
            out_frame   <= '0;
            out_message <= '0;
            out_enable  <= 1'b0;
        end else begin
            if (sample_fire) begin
                slot                       <= last_slot ? '0 : slot + 1'b1;
                out_frame[slot*BPS +: BPS] <= in_sample;
                out_message[slot]          <= embed_bit;
                if (bit_cnt != 4'd0) out_enable <= 1'b1;
            end else if (frame_fire) begin
                out_enable <= 1'b0;
            end
        end
    end

    // Bits leave the buffer MSB first; done latches forever once the last
    // byte's final bit has gone out.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            msg_buf   <= 8'd0;
            bit_cnt   <= 4'd0;
            last_flag <= 1'b0;
            done      <= 1'b0;
        end else if (byte_fire) begin
            msg_buf   <= in_msg_byte;
            bit_cnt   <= 4'd8;
            last_flag <= in_msg_last;
        end else if (sample_fire && (bit_cnt != 4'd0)) begin
            bit_cnt <= bit_cnt - 4'd1;
            if ((bit_cnt == 4'd1) && last_flag) begin
                done      <= 1'b1;
                last_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frame_assembler.sv
// Scoreboard bench for frame_assembler: stimulus queues expected frames, a
// monitor pops and compares each frame as it transfers downstream.
module tb_frame_assembler;

    localparam int BPS = 16;
    localparam int FS  = 8;
    localparam int FW  = BPS * FS;

    typedef struct packed {
        logic [FW-1:0] frame;
        logic [FS-1:0] message;
        logic          enable;
    } exp_t;

    logic           in_clk = 1'b0;
    logic           in_rst;
    logic [BPS-1:0] in_sample;
    logic           in_sample_valid;
    logic           out_sample_ready;
    logic [7:0]     in_msg_byte;
    logic           in_msg_valid;
    logic           in_msg_last;
    logic           out_msg_ready;
    logic [FW-1:0]  out_frame;
    logic [FS-1:0]  out_message;
    logic           out_enable;
    logic           out_valid;
    logic           in_ready;

    exp_t exp_q[$];
    exp_t mon_exp;
    int   tests_run    = 0;
    int   tests_failed = 0;

    frame_assembler #(.BPS(BPS), .FRAME_SIZE(FS)) dut (
        .in_clk          (in_clk),
        .in_rst          (in_rst),
        .in_sample       (in_sample),
        .in_sample_valid (in_sample_valid),
        .out_sample_ready(out_sample_ready),
        .in_msg_byte     (in_msg_byte),
        .in_msg_valid    (in_msg_valid),
        .in_msg_last     (in_msg_last),
        .out_msg_ready   (out_msg_ready),
        .out_frame       (out_frame),
        .out_message     (out_message),
        .out_enable      (out_enable),
        .out_valid       (out_valid),
        .in_ready        (in_ready)
    );

    always #5 in_clk = ~in_clk;

    task automatic check_output(input string name, input logic [FW-1:0] actual,
                                input logic [FW-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [FW-1:0] make_frame(input logic [BPS-1:0] base,
                                                 input logic [BPS-1:0] step);
        logic [FW-1:0] f;
        f = '0;
        for (int k = 0; k < FS; k++) f[k*BPS +: BPS] = base + BPS'(k) * step;
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic last);
        int   n  = 0;
        logic ok = 1'b0;
        in_msg_byte  = b;
        in_msg_last  = last;
        in_msg_valid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge in_clk);
            ok = out_msg_ready;
            @(posedge in_clk);
            #1;
            n++;
        end
        in_msg_valid = 1'b0;
        in_msg_last  = 1'b0;
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL byte handshake: timeout, byte %0h not accepted", b);
        end
    endtask

    task automatic send_sample(input logic [BPS-1:0] s);
        int   n  = 0;
        logic ok = 1'b0;
        in_sample       = s;
        in_sample_valid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge in_clk);
            ok = out_sample_ready;
            @(posedge in_clk);
            #1;
            n++;
        end
        in_sample_valid = 1'b0;
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL sample handshake: timeout, sample %0h not accepted", s);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge in_clk);
            #1;
            n++;
        end
        check_output("scoreboard drained", FW'(exp_q.size()), '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, " out_valid"},        FW'(out_valid),        '0);
        check_output({tag, " out_enable"},       FW'(out_enable),       '0);
        check_output({tag, " out_frame"},        out_frame,             '0);
        check_output({tag, " out_message"},      FW'(out_message),      '0);
        check_output({tag, " out_msg_ready"},    FW'(out_msg_ready),    FW'(1));
        check_output({tag, " out_sample_ready"}, FW'(out_sample_ready), '0);
    endtask

    // Monitor: a frame transfers on the next rising edge whenever valid and
    // ready are both high at the falling edge.
    always @(negedge in_clk) begin
        if (!in_rst && out_valid && in_ready) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected frame: got %0h, expected none", out_frame);
            end else begin
                mon_exp = exp_q.pop_front();
                check_output("frame data",    out_frame,         mon_exp.frame);
                check_output("frame message", FW'(out_message),  FW'(mon_exp.message));
                check_output("frame enable",  FW'(out_enable),   FW'(mon_exp.enable));
            end
        end
    end

    initial begin
        in_rst          = 1'b1;
        in_sample       = '0;
        in_sample_valid = 1'b0;
        in_msg_byte     = '0;
        in_msg_valid    = 1'b0;
        in_msg_last     = 1'b0;
        in_ready        = 1'b0;
        repeat (2) @(posedge in_clk);
        #1;
        check_reset_outputs("reset");
        in_rst = 1'b0;
        @(posedge in_clk);
        #1;

        // One full frame carrying 0xA5, then held off downstream for 5 cycles.
        send_byte(8'hA5, 1'b0);
        exp_q.push_back('{frame: make_frame(16'h1000, 16'd1), message: 8'hA5, enable: 1'b1});
        for (int k = 0; k < FS; k++) begin
            send_sample(16'h1000 + 16'(k));
            if (k == FS - 2) check_output("valid before last sample", FW'(out_valid), '0);
        end
        check_output("valid one cycle after last sample", FW'(out_valid), FW'(1));
        in_sample       = 16'hDEAD;
        in_sample_valid = 1'b1;
        repeat (5) begin
            @(negedge in_clk);
            check_output("hold out_valid",        FW'(out_valid),        FW'(1));
            check_output("hold out_sample_ready", FW'(out_sample_ready), '0);
            check_output("hold out_frame",        out_frame,             make_frame(16'h1000, 16'd1));
            check_output("hold out_message",      FW'(out_message),      FW'(8'hA5));
            @(posedge in_clk);
            #1;
        end
        in_sample_valid = 1'b0;
        in_ready        = 1'b1;
        @(posedge in_clk);
        #1;
        check_output("valid after transfer",  FW'(out_valid),  '0);
        check_output("enable after transfer", FW'(out_enable), '0);
        wait_drain();

        // No message byte available: samples must be refused.
        in_sample       = 16'h2222;
        in_sample_valid = 1'b1;
        repeat (4) begin
            @(negedge in_clk);
            check_output("no byte sample_ready", FW'(out_sample_ready), '0);
            check_output("no byte msg_ready",    FW'(out_msg_ready),    FW'(1));
            @(posedge in_clk);
            #1;
        end
        in_sample_valid = 1'b0;

        // Final byte 0xF0 followed by a pass-through frame.
        send_byte(8'hF0, 1'b1);
        exp_q.push_back('{frame: make_frame(16'h0001, 16'd0), message: 8'h0F, enable: 1'b1});
        exp_q.push_back('{frame: make_frame(16'h0001, 16'd0), message: 8'hFF, enable: 1'b0});
        for (int k = 0; k < 2 * FS; k++) send_sample(16'h0001);
        wait_drain();
        check_output("msg_ready after done", FW'(out_msg_ready), '0);

        // Reset clears done; then abort a partial frame with an async reset.
        in_rst = 1'b1;
        @(posedge in_clk);
        #1;
        in_rst = 1'b0;
        @(posedge in_clk);
        #1;
        check_output("msg_ready after reset", FW'(out_msg_ready), FW'(1));
        send_byte(8'h81, 1'b0);
        for (int k = 0; k < 3; k++) send_sample(16'h5000 + 16'(k));
        #3;
        in_rst = 1'b1;
        #1;
        check_reset_outputs("mid-frame reset");
        @(posedge in_clk);
        #1;
        in_rst = 1'b0;
        send_byte(8'h6B, 1'b1);
        exp_q.push_back('{frame: make_frame(16'h3000, 16'd1), message: 8'hD6, enable: 1'b1});
        for (int k = 0; k < FS; k++) send_sample(16'h3000 + 16'(k));
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
